// File: rtl/compare_unit.sv
// compare_unit: multi-cycle chunked X-Y comparator (slt/sltu/eq/ne/sle/sleu).
// Subtracts CHUNK bits per cycle LSB first and reports a zero-extended flag plus signed overflow.
module compare_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] xr, yr, diff;
  logic [2:0] mode_r;
  logic [IW-1:0] idx;
  logic carry, zacc;
  logic [CHUNK:0] s;
  logic last, eq, cin_msb, v, slt, sltu, f;
  assign s = {1'b0, xr[CHUNK-1:0]} + {1'b0, ~yr[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
  assign last = idx == IW'(N - 1);
  assign eq = zacc & ~|s[CHUNK-1:0];
  // carry into the sign bit recovered from the sum bit: s = a ^ b ^ cin
  assign cin_msb = xr[CHUNK-1] ^ ~yr[CHUNK-1] ^ s[CHUNK-1];
  assign v = cin_msb ^ s[CHUNK];
  assign slt = s[CHUNK-1] ^ v;
  assign sltu = ~s[CHUNK];
  always_comb begin
    f = mode_r == 3'd0 ? slt :
        mode_r == 3'd1 ? sltu :
        mode_r == 3'd2 ? eq :
        mode_r == 3'd3 ? ~eq :
        mode_r == 3'd4 ? (slt | eq) :
        mode_r == 3'd5 ? (sltu | eq) : 1'b0;
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign result = {{(WIDTH-1){1'b0}}, flag};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      xr <= '0;
      yr <= '0;
      diff <= '0;
      mode_r <= '0;
      idx <= '0;
      carry <= 1'b0;
      zacc <= 1'b0;
      flag <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr <= x;
          yr <= y;
          mode_r <= mode;
          idx <= '0;
          carry <= 1'b1;
          zacc <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          xr <= xr >> CHUNK;
          yr <= yr >> CHUNK;
          diff <= WIDTH'({s[CHUNK-1:0], diff} >> CHUNK);
          carry <= s[CHUNK];
          zacc <= eq;
          idx <= idx + IW'(1);
          if (last) begin
            flag <= f;
            ovf <= v;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_compare_unit.sv
// tb_compare_unit: scoreboard bench for compare_unit at CHUNK=4 and CHUNK=16.
module tb_compare_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic [2:0] mode = '0;
  logic iv0 = 1'b0, iv1 = 1'b0, or0 = 1'b0, or1 = 1'b0;
  logic ir0, ir1, ov0, ov1, fl0, fl1, of0, of1;
  logic [15:0] rs0, rs1;
  int checks = 0;
  int failures = 0;
  typedef struct {logic f; logic o;} exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  compare_unit #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .x(x), .y(y), .mode(mode),
    .out_valid(ov0), .out_ready(or0), .flag(fl0), .result(rs0), .ovf(of0));
  compare_unit #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .x(x), .y(y), .mode(mode),
    .out_valid(ov1), .out_ready(or1), .flag(fl1), .result(rs1), .ovf(of1));

  function automatic exp_t model(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [15:0] d;
    logic lt, ltu, q;
    d = a - b;
    lt = $signed(a) < $signed(b);
    ltu = a < b;
    q = a == b;
    e.o = (a[15] != b[15]) && (d[15] != a[15]);
    e.f = m == 3'd0 ? lt : m == 3'd1 ? ltu : m == 3'd2 ? q : m == 3'd3 ? !q :
          m == 3'd4 ? (lt | q) : m == 3'd5 ? (ltu | q) : 1'b0;
    return e;
  endfunction

  // Offer one op to unit u, then wait for its result, check it against the scoreboard and consume it.
  task automatic op(input bit u, input logic [2:0] m, input logic [15:0] a, input logic [15:0] b, input string nm);
    exp_t e;
    int n;
    int lat;
    logic rdy;
    lat = u ? 1 : 4;
    sbq.push_back(model(m, a, b));
    x = a; y = b; mode = m;
    rdy = u ? ir1 : ir0;
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL %s in_ready_before_accept got=%b want=1", nm, rdy); end
    if (u) iv1 = 1'b1; else iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0; iv1 = 1'b0;
    rdy = u ? ir1 : ir0;
    checks++;
    if (rdy !== 1'b0) begin failures++; $display("FAIL %s in_ready_busy got=%b want=0", nm, rdy); end
    n = 0;
    while (!(u ? ov1 : ov0) && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != lat) begin failures++; $display("FAIL %s latency got=%0d want=%0d", nm, n, lat); end
    e = sbq.pop_front();
    checks++;
    if ((u ? fl1 : fl0) !== e.f || (u ? rs1 : rs0) !== {15'd0, e.f} || (u ? of1 : of0) !== e.o) begin
      failures++;
      $display("FAIL %s result got flag=%b result=%h ovf=%b want flag=%b result=%h ovf=%b", nm,
               u ? fl1 : fl0, u ? rs1 : rs0, u ? of1 : of0, e.f, {15'd0, e.f}, e.o);
    end
    if (u) or1 = 1'b1; else or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0; or1 = 1'b0;
    checks++;
    if ((u ? ov1 : ov0) !== 1'b0 || (u ? ir1 : ir0) !== 1'b1 || (u ? fl1 : fl0) !== e.f) begin
      failures++;
      $display("FAIL %s after_handshake got out_valid=%b in_ready=%b flag=%b want 0 1 %b", nm,
               u ? ov1 : ov0, u ? ir1 : ir0, u ? fl1 : fl0, e.f);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ov0, ir0, fl0, rs0, of0, ov1, ir1, fl1, rs1, of1} !== {1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got ov=%b ir=%b fl=%b rs=%h of=%b / ov=%b ir=%b fl=%b rs=%h of=%b want 0 1 0 0000 0",
               ov0, ir0, fl0, rs0, of0, ov1, ir1, fl1, rs1, of1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed(input bit u);
    op(u, 3'd0, 16'hFFFF, 16'h0001, "slt_neg");
    op(u, 3'd1, 16'hFFFF, 16'h0001, "sltu_big");
    op(u, 3'd1, 16'h0001, 16'hFFFF, "sltu_small");
    op(u, 3'd0, 16'h8000, 16'h0001, "slt_ovf_t");
    op(u, 3'd0, 16'h7FFF, 16'hFFFF, "slt_ovf_f");
    op(u, 3'd2, 16'h1234, 16'h1234, "eq_t");
    op(u, 3'd3, 16'h1234, 16'h1234, "ne_f");
    op(u, 3'd4, 16'h1234, 16'h1234, "sle_eq");
    op(u, 3'd5, 16'h1234, 16'h1234, "sleu_eq");
    op(u, 3'd6, 16'h1234, 16'h1234, "reserved");
    op(u, 3'd2, 16'h1234, 16'h1235, "eq_f");
    op(u, 3'd4, 16'h0005, 16'h0003, "sle_gt");
    op(u, 3'd5, 16'h0003, 16'h0005, "sleu_lt");
    op(u, 3'd3, 16'h0000, 16'h8000, "ne_t");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int n;
    logic f0, o0;
    logic [15:0] r0;
    sbq.push_back(model(3'd0, 16'h8000, 16'h0001));
    x = 16'h8000; y = 16'h0001; mode = 3'd0; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    n = 0;
    while (!ov0 && n < 20) begin @(negedge clk); n++; end
    e = sbq.pop_front();
    checks++;
    if (n != 4 || fl0 !== e.f || of0 !== e.o) begin
      failures++;
      $display("FAIL bp_first got lat=%0d flag=%b ovf=%b want 4 %b %b", n, fl0, of0, e.f, e.o);
    end
    f0 = fl0; r0 = rs0; o0 = of0;
    mode = 3'd1; iv0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x = 16'($urandom); y = 16'($urandom);
      @(negedge clk);
      checks++;
      if (ov0 !== 1'b1 || ir0 !== 1'b0 || fl0 !== f0 || rs0 !== r0 || of0 !== o0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b fl=%b rs=%h of=%b want 1 0 %b %h %b", i, ov0, ir0, fl0, rs0, of0, f0, r0, o0);
      end
    end
    x = 16'h0001; y = 16'hFFFF;
    sbq.push_back(model(3'd1, x, y));
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    checks++;
    if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got ov=%b ir=%b want 0 1", ov0, ir0);
    end
    @(negedge clk);
    iv0 = 1'b0;
    checks++;
    if (ir0 !== 1'b0) begin failures++; $display("FAIL bp_pending_accept got in_ready=%b want 0", ir0); end
    n = 0;
    while (!ov0 && n < 20) begin @(negedge clk); n++; end
    e = sbq.pop_front();
    checks++;
    if (n != 4 || fl0 !== e.f || rs0 !== {15'd0, e.f}) begin
      failures++;
      $display("FAIL bp_pending got lat=%0d flag=%b result=%h want 4 %b %h", n, fl0, rs0, e.f, {15'd0, e.f});
    end
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
  endtask

  task automatic test_async_reset;
    op(1'b0, 3'd0, 16'hFFFF, 16'h0001, "pre_reset");
    x = 16'h1234; y = 16'h1234; mode = 3'd2; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0 || rs0 !== 16'h0 || ir0 !== 1'b1 || fl0 !== 1'b0 || of0 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got ov=%b rs=%h ir=%b fl=%b of=%b want 0 0000 1 0 0", ov0, rs0, ir0, fl0, of0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b0, 3'd0, 16'h0003, 16'h0005, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed(1'b0);
    test_back_to_back();
    test_async_reset();
    test_directed(1'b1);
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
